// File: rtl/zbuff_hit_arb.sv
// Two-lane hit arbiter in front of the z-buffer fragment port: per-lane FIFOs,
// a round-robin merge with a stall-locked grant, and a flush sequencer.
module zbuff_hit_arb #(
    parameter int SIGFIG     = 24,
    parameter int AXIS       = 3,
    parameter int COLORS     = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hit0_valid,
    output logic                     hit0_ready,
    input  logic [AXIS*SIGFIG-1:0]   hit0_pos,
    input  logic [COLORS*SIGFIG-1:0] hit0_color,
    input  logic                     hit1_valid,
    output logic                     hit1_ready,
    input  logic [AXIS*SIGFIG-1:0]   hit1_pos,
    input  logic [COLORS*SIGFIG-1:0] hit1_color,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [AXIS*SIGFIG-1:0]   out_pos,
    output logic [COLORS*SIGFIG-1:0] out_color,
    output logic                     out_lane,
    input  logic                     flush_req,
    output logic                     flush_done,
    output logic                     busy,
    output logic [CNT_W-1:0]         cnt0,
    output logic [CNT_W-1:0]         cnt1,
    output logic [1:0]               dbg_state
);

    localparam int PW = AXIS * SIGFIG;
    localparam int CW = COLORS * SIGFIG;
    localparam int DW = PW + CW;
    localparam int AW = $clog2(FIFO_DEPTH);

    // Handshake: a beat moves on any port exactly when valid && ready are both
    // high at a rising clk edge; valid never waits on ready, and ready never
    // looks at valid or at a same-cycle pop.
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [1:0]         push, pop, empty, full, empty_nx;
    logic [1:0][DW-1:0] wdata;
    logic [1:0][DW-1:0] head;

    logic grant, last_grant, hold, held_grant, fire;
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    assign wdata[0] = {hit0_color, hit0_pos};
    assign wdata[1] = {hit1_color, hit1_pos};

    assign hit0_ready = (state == S_RUN) && !full[0];
    assign hit1_ready = (state == S_RUN) && !full[1];
    assign push[0]    = hit0_valid && hit0_ready;
    assign push[1]    = hit1_valid && hit1_ready;

    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic [DW-1:0] mem [FIFO_DEPTH];
        logic [AW-1:0] wr_ptr, rd_ptr;
        logic [AW:0]   occ, occ_nx;

        assign occ_nx      = occ + (AW+1)'(push[l]) - (AW+1)'(pop[l]);
        assign full[l]     = (occ == (AW+1)'(FIFO_DEPTH));
        assign empty[l]    = (occ == '0);
        assign empty_nx[l] = (occ_nx == '0);
        assign head[l]     = mem[rd_ptr];

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push[l]) wr_ptr <= wr_ptr + AW'(1);
                if (pop[l])  rd_ptr <= rd_ptr + AW'(1);
                occ <= occ_nx;
            end
        end

        // Payload storage needs no reset; occupancy alone decides validity.
        always_ff @(posedge clk) begin
            if (push[l]) mem[wr_ptr] <= wdata[l];
        end
    end

    // Once a fragment stalls, the grant is frozen until it is consumed so a
    // late arrival on the other lane cannot swap the presented fragment.
    always_comb begin
        grant = 1'b0;
        if (hold)
            grant = held_grant;
        else if (!empty[0] && !empty[1])
            grant = !last_grant;
        else if (empty[0])
            grant = 1'b1;
    end

    assign out_valid = !empty[0] || !empty[1];
    assign out_pos   = head[grant][PW-1:0];
    assign out_color = head[grant][DW-1:PW];
    assign out_lane  = grant;
    assign fire      = out_valid && out_ready;
    assign pop[0]    = fire && !grant;
    assign pop[1]    = fire && grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            hold       <= 1'b0;
            held_grant <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            if (fire) last_grant <= grant;
            hold       <= out_valid && !out_ready;
            held_grant <= grant;
            cnt0_q     <= cnt0_q + CNT_W'(pop[0]);
            cnt1_q     <= cnt1_q + CNT_W'(pop[1]);
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;

    always_ff @(posedge clk) begin
        if (rst) state <= S_RUN;
        else     state <= state_nx;
    end

    // DRAIN exit looks at post-pop occupancy, so the last pop and the move to
    // DONE share one edge.
    always_comb begin
        state_nx = state;
        case (state)
            S_RUN:   if (flush_req) state_nx = S_DRAIN;
            S_DRAIN: if (empty_nx[0] && empty_nx[1]) state_nx = S_DONE;
            S_DONE:  state_nx = S_RUN;
            default: state_nx = S_RUN;
        endcase
    end

    assign flush_done = (state == S_DONE);
    assign busy       = !empty[0] || !empty[1] || (state != S_RUN);
    assign dbg_state  = state;

endmodule

// File: tb/tb_zbuff_hit_arb.sv
// Directed bench for zbuff_hit_arb: hand-ordered expected fragments go into a
// queue that a negedge monitor pops on every fragment transfer.
module tb_zbuff_hit_arb;

  localparam int SIGFIG = 24;
  localparam int PW     = 3 * SIGFIG;
  localparam int CW     = 3 * SIGFIG;
  localparam int EW     = 1 + PW + CW;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              hit0_valid = 1'b0, hit1_valid = 1'b0;
  logic              hit0_ready, hit1_ready;
  logic [PW-1:0]     hit0_pos = '0, hit1_pos = '0;
  logic [CW-1:0]     hit0_color = '0, hit1_color = '0;
  logic              out_valid, out_lane;
  logic              out_ready = 1'b0;
  logic [PW-1:0]     out_pos;
  logic [CW-1:0]     out_color;
  logic              flush_req = 1'b0;
  logic              flush_done, busy;
  logic [CNT_W-1:0]  cnt0, cnt1;
  logic [1:0]        dbg_state;

  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  zbuff_hit_arb dut (
    .clk(clk), .rst(rst),
    .hit0_valid(hit0_valid), .hit0_ready(hit0_ready), .hit0_pos(hit0_pos), .hit0_color(hit0_color),
    .hit1_valid(hit1_valid), .hit1_ready(hit1_ready), .hit1_pos(hit1_pos), .hit1_color(hit1_color),
    .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos), .out_color(out_color),
    .out_lane(out_lane), .flush_req(flush_req), .flush_done(flush_done), .busy(busy),
    .cnt0(cnt0), .cnt1(cnt1), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- helpers ----------------
  function automatic logic [PW-1:0] mk_pos(input logic [23:0] x);
    return {x + 24'h000300, x + 24'h000200, x};
  endfunction

  function automatic logic [CW-1:0] mk_color(input logic [23:0] x);
    return {~x, x + 24'h000010, x | 24'hC00000};
  endfunction

  task automatic exp_push(input logic lane, input logic [23:0] x);
    exp_q.push_back({lane, mk_pos(x), mk_color(x)});
  endtask

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_lane(input logic lane, input logic [23:0] first_x, input int n);
    for (int i = 0; i < n; i++) begin
      logic [23:0] x;
      logic        rdy;
      int          budget;
      x = first_x + 24'(i);
      @(negedge clk);
      if (lane) begin
        hit1_valid = 1'b1; hit1_pos = mk_pos(x); hit1_color = mk_color(x);
      end else begin
        hit0_valid = 1'b1; hit0_pos = mk_pos(x); hit0_color = mk_color(x);
      end
      rdy    = lane ? hit1_ready : hit0_ready;
      budget = 0;
      while (!rdy && budget < 200) begin
        @(negedge clk);
        rdy = lane ? hit1_ready : hit0_ready;
        budget++;
      end
      if (!rdy) begin
        checks++;
        failures++;
        $display("FAIL push_timeout lane=%0d x=%0h: ready stayed 0, required 1", lane, x);
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    if (lane) hit1_valid = 1'b0;
    else      hit0_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(name, 160'(exp_q.size()), 160'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL frag_unexpected: got lane=%0d pos=%0h, required no fragment", out_lane, out_pos);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({out_lane, out_pos, out_color} !== e) begin
          failures++;
          $display("FAIL frag: got lane=%0d x=%0h color=%0h, required lane=%0d x=%0h color=%0h",
                   out_lane, out_pos[23:0], out_color, e[EW-1], e[CW+23:CW], e[CW-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    check("reset_out_valid", 160'(out_valid), 160'd0);
    check("reset_busy_done", 160'({busy, flush_done}), 160'd0);
    check("reset_cnts", 160'({cnt0, cnt1}), 160'd0);
    check("reset_ready", 160'({hit0_ready, hit1_ready}), 160'b11);
    check("reset_state", 160'(dbg_state), 160'd0);

    // T1: lane 0 alone, in order
    out_ready = 1'b1;
    exp_push(1'b0, 24'h1); exp_push(1'b0, 24'h2); exp_push(1'b0, 24'h3);
    drive_lane(1'b0, 24'h1, 3);
    wait_drain("t1_drain");
    check("t1_cnt0", 160'(cnt0), 160'd3);
    check("t1_cnt1", 160'(cnt1), 160'd0);

    // T2: both lanes streaming, lane 0 wins the first tie
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_push(1'b0, 24'h10 + 24'(i));
      exp_push(1'b1, 24'h20 + 24'(i));
    end
    fork
      drive_lane(1'b0, 24'h10, 4);
      drive_lane(1'b1, 24'h20, 4);
    join
    wait_drain("t2_drain");
    check("t2_cnts", 160'({cnt0, cnt1}), 160'({32'd4, 32'd4}));

    // T3: fill both FIFOs under stall; head must hold
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_push(1'b0, 24'h30 + 24'(i));
      exp_push(1'b1, 24'h40 + 24'(i));
    end
    fork
      drive_lane(1'b0, 24'h30, 4);
      drive_lane(1'b1, 24'h40, 4);
    join
    check("t3_full_ready", 160'({hit0_ready, hit1_ready}), 160'd0);
    for (int i = 0; i < 10; i++) begin
      check("t3_stall_hold", 160'({out_valid, out_lane, out_pos}), 160'({1'b1, 1'b0, mk_pos(24'h30)}));
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_drain("t3_drain");
    check("t3_cnts", 160'({cnt0, cnt1}), 160'({32'd4, 32'd4}));

    // T4: flush with 2 + 3 buffered
    do_reset();
    out_ready = 1'b0;
    exp_push(1'b0, 24'h60); exp_push(1'b1, 24'h70);
    exp_push(1'b0, 24'h61); exp_push(1'b1, 24'h71);
    exp_push(1'b1, 24'h72);
    fork
      drive_lane(1'b0, 24'h60, 2);
      drive_lane(1'b1, 24'h70, 3);
    join
    check("t4_pre_ready0", 160'(hit0_ready), 160'd1);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    check("t4_drain_ready", 160'({hit0_ready, hit1_ready}), 160'd0);
    check("t4_drain_busy_done", 160'({busy, flush_done}), 160'b10);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("t4_done_early", 160'(flush_done), 160'd0);
    @(negedge clk);
    check("t4_done_pulse", 160'({flush_done, busy, out_valid}), 160'b110);
    @(negedge clk);
    check("t4_done_end", 160'({flush_done, busy, hit0_ready}), 160'b001);
    wait_drain("t4_drain");

    // Flush with nothing buffered: one DRAIN cycle, then DONE
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    check("fe_drain", 160'({flush_done, busy}), 160'b01);
    @(negedge clk);
    check("fe_done", 160'({flush_done, busy}), 160'b11);
    @(negedge clk);
    check("fe_run", 160'({flush_done, busy}), 160'b00);

    // T5: reset with 4 fragments buffered
    do_reset();
    out_ready = 1'b1;
    exp_push(1'b0, 24'h50);
    drive_lane(1'b0, 24'h50, 1);
    wait_drain("t5_pre_drain");
    check("t5_pre_cnt0", 160'(cnt0), 160'd1);
    out_ready = 1'b0;
    fork
      drive_lane(1'b0, 24'h80, 2);
      drive_lane(1'b1, 24'h90, 2);
    join
    check("t5_pre_busy", 160'({busy, out_valid}), 160'b11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_out", 160'({out_valid, busy}), 160'd0);
    check("t5_rst_cnt", 160'({cnt0, cnt1}), 160'd0);
    exp_push(1'b0, 24'hA0); exp_push(1'b1, 24'hB0);
    fork
      drive_lane(1'b0, 24'hA0, 1);
      drive_lane(1'b1, 24'hB0, 1);
    join
    out_ready = 1'b1;
    wait_drain("t5_tie_drain");

    // T6: counter wrap
    do_reset();
    out_ready = 1'b1;
    force dut.cnt0_q = {CNT_W{1'b1}};
    @(posedge clk);
    @(negedge clk);
    release dut.cnt0_q;
    @(negedge clk);
    check("t6_preset", 160'(cnt0), 160'({CNT_W{1'b1}}));
    exp_push(1'b0, 24'hC0);
    drive_lane(1'b0, 24'hC0, 1);
    wait_drain("t6_drain");
    check("t6_wrap", 160'({cnt0, cnt1}), 160'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
